// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM encoding,
// datapath/requester sizing and the packing of the response flag nibble.
package alu_arb_pkg;

   localparam int DATA_W = 16;
   localparam int REQ_N  = 2;
   localparam int FSEL_W = 4;
   localparam int FLAG_W = 4;

   // Bit positions inside RSP_FLAGS
   localparam int FLAG_C = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_S = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arbState_t;

   function automatic logic [FLAG_W-1:0] packFlags(input logic c, input logic z,
                                                    input logic s, input logic v);
      logic [FLAG_W-1:0] f;
      f         = '0;
      f[FLAG_C] = c;
      f[FLAG_Z] = z;
      f[FLAG_S] = s;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant selection. A lone valid requester wins; on contention the
// priority pointer decides. lockMask removes requesters from consideration
// (all ones when no lock is in force).
module rr_arb2
   import alu_arb_pkg::*;
(
   input  logic [REQ_N-1:0] valid,
   input  logic             prio,
   input  logic [REQ_N-1:0] lockMask,
   output logic             grantIdx,
   output logic             grantVld
);

   logic [REQ_N-1:0] cand;

   // Pick the winner among the unmasked valid requesters
   always_comb begin
      cand     = valid & lockMask;
      grantVld = |cand;
      grantIdx = 1'b0;
      case (cand)
         2'b10:   grantIdx = 1'b1;
         2'b11:   grantIdx = prio;
         default: grantIdx = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters.
// Sequence per operation: IDLE (grant/accept) -> EXEC (operands on ALU_*,
// result captured) -> RESP (result held until the winner takes it).
// Optional feature: define ALU_ARB_LOCK_EN to add REQ_LOCK, which pins the
// grant to a requester until its next accepted request clears the lock.
module alu_arbiter
   import alu_arb_pkg::*;
(
   input  logic                      CLK,
   input  logic                      RESET_N,
   input  logic [REQ_N-1:0]          REQ_VALID,
   output logic [REQ_N-1:0]          REQ_READY,
   input  logic [REQ_N*DATA_W-1:0]   REQ_A,
   input  logic [REQ_N*DATA_W-1:0]   REQ_B,
   input  logic [REQ_N*FSEL_W-1:0]   REQ_FSEL,
   input  logic [REQ_N-1:0]          REQ_CIN,
`ifdef ALU_ARB_LOCK_EN
   input  logic [REQ_N-1:0]          REQ_LOCK,
`endif
   output logic [REQ_N-1:0]          RSP_VALID,
   input  logic [REQ_N-1:0]          RSP_READY,
   output logic [DATA_W-1:0]         RSP_FOUT,
   output logic [FLAG_W-1:0]         RSP_FLAGS,
   output logic [DATA_W-1:0]         ALU_A,
   output logic [DATA_W-1:0]         ALU_B,
   output logic [FSEL_W-1:0]         ALU_FSEL,
   output logic                      ALU_CIN,
   input  logic [DATA_W-1:0]         ALU_FOUT,
   input  logic                      ALU_C,
   input  logic                      ALU_Z,
   input  logic                      ALU_S,
   input  logic                      ALU_V,
   output logic                      BUSY,
   output logic [15:0]               OP_COUNT
);

   arbState_t           state;
   arbState_t           stateNext;
   logic                prio;
   logic [15:0]         opCount;

   logic                grantIdx;
   logic                grantVld;
   logic [REQ_N-1:0]    lockMask;
   logic                prioHold;
   logic                accept;
   logic                rspFire;

   logic [DATA_W-1:0]   selA;
   logic [DATA_W-1:0]   selB;
   logic [FSEL_W-1:0]   selFsel;
   logic                selCin;

   logic [DATA_W-1:0]   aOp_p1;
   logic [DATA_W-1:0]   bOp_p1;
   logic [FSEL_W-1:0]   fsel_p1;
   logic                cin_p1;
   logic                grant_p1;

   logic [DATA_W-1:0]   fout_p2;
   logic [FLAG_W-1:0]   flags_p2;

   rr_arb2 uArb (
      .valid    (REQ_VALID),
      .prio     (prio),
      .lockMask (lockMask),
      .grantIdx (grantIdx),
      .grantVld (grantVld)
   );

`ifdef ALU_ARB_LOCK_EN
   logic lockActive;
   logic lockOwner;

   assign lockMask = lockActive ? (lockOwner ? 2'b10 : 2'b01) : 2'b11;
   assign prioHold = lockActive;

   // Track lock ownership; only the owner can be accepted while locked,
   // so its LOCK bit alone decides whether the lock persists
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         lockActive <= 1'b0;
         lockOwner  <= 1'b0;
      end else if (accept) begin
         lockActive <= REQ_LOCK[grantIdx];
         if (REQ_LOCK[grantIdx]) lockOwner <= grantIdx;
      end
   end
`else
   assign lockMask = 2'b11;
   assign prioHold = 1'b0;
`endif

   assign accept  = (state == IDLE) && grantVld;
   assign rspFire = (state == RESP) && RSP_READY[grant_p1];

   assign selA    = grantIdx ? REQ_A[2*DATA_W-1 -: DATA_W]    : REQ_A[DATA_W-1:0];
   assign selB    = grantIdx ? REQ_B[2*DATA_W-1 -: DATA_W]    : REQ_B[DATA_W-1:0];
   assign selFsel = grantIdx ? REQ_FSEL[2*FSEL_W-1 -: FSEL_W] : REQ_FSEL[FSEL_W-1:0];
   assign selCin  = REQ_CIN[grantIdx];

   // State register
   always_ff @(posedge CLK) begin
      if (!RESET_N) state <= IDLE;
      else          state <= stateNext;
   end

   // Next state and handshake outputs; READY only in IDLE, VALID only in RESP
   always_comb begin
      stateNext = state;
      REQ_READY = '0;
      RSP_VALID = '0;
      case (state)
         IDLE: begin
            if (grantVld) begin
               REQ_READY[grantIdx] = 1'b1;
               stateNext           = EXEC;
            end
         end
         EXEC: stateNext = RESP;
         RESP: begin
            RSP_VALID[grant_p1] = 1'b1;
            if (RSP_READY[grant_p1]) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // ---- stage p1: accepted operands, held on ALU_* until the next accept ----
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         aOp_p1   <= '0;
         bOp_p1   <= '0;
         fsel_p1  <= '0;
         cin_p1   <= 1'b0;
         grant_p1 <= 1'b0;
      end else if (accept) begin
         aOp_p1   <= selA;
         bOp_p1   <= selB;
         fsel_p1  <= selFsel;
         cin_p1   <= selCin;
         grant_p1 <= grantIdx;
      end
   end

   // ---- stage p2: ALU result captured at the end of EXEC ----
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         fout_p2  <= '0;
         flags_p2 <= '0;
      end else if (state == EXEC) begin
         fout_p2  <= ALU_FOUT;
         flags_p2 <= packFlags(ALU_C, ALU_Z, ALU_S, ALU_V);
      end
   end

   // Completion bookkeeping: operation count and round-robin pointer
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         prio    <= 1'b0;
         opCount <= '0;
      end else if (rspFire) begin
         opCount <= opCount + 16'd1;
         if (!prioHold) prio <= ~grant_p1;
      end
   end

   assign ALU_A     = aOp_p1;
   assign ALU_B     = bOp_p1;
   assign ALU_FSEL  = fsel_p1;
   assign ALU_CIN   = cin_p1;
   assign RSP_FOUT  = fout_p2;
   assign RSP_FLAGS = flags_p2;
   assign BUSY      = (state != IDLE);
   assign OP_COUNT  = opCount;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: models the external ALU, keeps a scoreboard of
// expected responses filled at acceptance and drained at response handshake,
// and checks timing, backpressure, reset and round-robin/lock behaviour.
module tb_alu_arbiter;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic [1:0]  REQ_VALID;
   logic [1:0]  REQ_READY;
   logic [31:0] REQ_A;
   logic [31:0] REQ_B;
   logic [7:0]  REQ_FSEL;
   logic [1:0]  REQ_CIN;
`ifdef ALU_ARB_LOCK_EN
   logic [1:0]  REQ_LOCK;
`endif
   logic [1:0]  RSP_VALID;
   logic [1:0]  RSP_READY;
   logic [15:0] RSP_FOUT;
   logic [3:0]  RSP_FLAGS;
   logic [15:0] ALU_A;
   logic [15:0] ALU_B;
   logic [3:0]  ALU_FSEL;
   logic        ALU_CIN;
   logic [15:0] ALU_FOUT;
   logic        ALU_C;
   logic        ALU_Z;
   logic        ALU_S;
   logic        ALU_V;
   logic        BUSY;
   logic [15:0] OP_COUNT;

   int          total = 0;
   int          bad   = 0;
   logic [20:0] sbQ[$];
   logic [20:0] sbE;
   logic        sbG;
   logic [15:0] fo;
   logic [3:0]  fl;

   alu_arbiter dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .REQ_VALID (REQ_VALID),
      .REQ_READY (REQ_READY),
      .REQ_A     (REQ_A),
      .REQ_B     (REQ_B),
      .REQ_FSEL  (REQ_FSEL),
      .REQ_CIN   (REQ_CIN),
`ifdef ALU_ARB_LOCK_EN
      .REQ_LOCK  (REQ_LOCK),
`endif
      .RSP_VALID (RSP_VALID),
      .RSP_READY (RSP_READY),
      .RSP_FOUT  (RSP_FOUT),
      .RSP_FLAGS (RSP_FLAGS),
      .ALU_A     (ALU_A),
      .ALU_B     (ALU_B),
      .ALU_FSEL  (ALU_FSEL),
      .ALU_CIN   (ALU_CIN),
      .ALU_FOUT  (ALU_FOUT),
      .ALU_C     (ALU_C),
      .ALU_Z     (ALU_Z),
      .ALU_S     (ALU_S),
      .ALU_V     (ALU_V),
      .BUSY      (BUSY),
      .OP_COUNT  (OP_COUNT)
   );

   always #5 CLK = ~CLK;

   // Reference ALU: 0 = A+B+CIN, 1 = A-B via A+~B+CIN, others = A&B.
   // Returns {C,Z,S,V,FOUT}.
   function automatic logic [19:0] bAlu(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] fsel, input logic cin);
      logic [16:0] s;
      logic [15:0] r;
      logic        c;
      logic        v;
      s = '0; c = 1'b0; v = 1'b0;
      case (fsel)
         4'd0: begin
            s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            r = s[15:0]; c = s[16];
            v = (a[15] == b[15]) && (r[15] != a[15]);
         end
         4'd1: begin
            s = {1'b0, a} + {1'b0, ~b} + {16'd0, cin};
            r = s[15:0]; c = s[16];
            v = (a[15] != b[15]) && (r[15] != a[15]);
         end
         default: r = a & b;
      endcase
      return {c, (r == 16'd0), r[15], v, r};
   endfunction

   always_comb {ALU_C, ALU_Z, ALU_S, ALU_V, ALU_FOUT} = bAlu(ALU_A, ALU_B, ALU_FSEL, ALU_CIN);

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Scoreboard: push on acceptance, pop and compare on response handshake
   always @(negedge CLK) begin
      if (!RESET_N) begin
         sbQ.delete();
      end else begin
         if ((REQ_VALID & REQ_READY) != 2'b00) begin
            checkVal("readyOneHot", $countones(REQ_READY), 1);
            sbG = REQ_READY[1];
            sbQ.push_back({sbG, bAlu(REQ_A[sbG*16 +: 16], REQ_B[sbG*16 +: 16],
                                     REQ_FSEL[sbG*4 +: 4], REQ_CIN[sbG])});
         end
         if ((RSP_VALID & RSP_READY) != 2'b00) begin
            if (sbQ.size() == 0) begin
               checkVal("orphanRsp", 1, 0);
            end else begin
               sbE = sbQ.pop_front();
               checkVal("rspIdx", {31'd0, RSP_VALID[1]}, {31'd0, sbE[20]});
               checkVal("rspOneHot", $countones(RSP_VALID), 1);
               checkVal("rspFout", RSP_FOUT, sbE[15:0]);
               checkVal("rspFlags", RSP_FLAGS, sbE[19:16]);
            end
         end
      end
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic setReq(input int n, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] fsel, input logic cin);
      REQ_A[n*16 +: 16]  = a;
      REQ_B[n*16 +: 16]  = b;
      REQ_FSEL[n*4 +: 4] = fsel;
      REQ_CIN[n]         = cin;
      REQ_VALID[n]       = 1'b1;
   endtask

   // Wait for a grant, check who won, then step into EXEC
   task automatic waitGrant(input string tag, input logic [1:0] expMask, input logic drop);
      int n;
      logic [1:0] got;
      n = 0;
      @(negedge CLK);
      while (REQ_READY == 2'b00 && n < 20) begin
         @(negedge CLK);
         n++;
      end
      got = REQ_READY;
      checkVal(tag, {30'd0, got}, {30'd0, expMask});
      tick;
      if (drop) REQ_VALID = REQ_VALID & ~got;
   endtask

   // Wait for the response handshake, return the result, step into IDLE
   task automatic waitDone(input string tag, output logic [15:0] fout, output logic [3:0] flags);
      int n;
      n = 0;
      @(negedge CLK);
      while ((RSP_VALID & RSP_READY) == 2'b00 && n < 20) begin
         @(negedge CLK);
         n++;
      end
      if ((RSP_VALID & RSP_READY) == 2'b00) checkVal({tag, "Timeout"}, 0, 1);
      fout  = RSP_FOUT;
      flags = RSP_FLAGS;
      tick;
   endtask

   task automatic doReset;
      RESET_N   = 1'b0;
      REQ_VALID = 2'b00;
      tick;
      tick;
      RESET_N   = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET_N = 1'b0; REQ_VALID = '0; REQ_A = '0; REQ_B = '0; REQ_FSEL = '0;
      REQ_CIN = '0; RSP_READY = '0;
`ifdef ALU_ARB_LOCK_EN
      REQ_LOCK = '0;
`endif
      tick; tick; tick;
      @(negedge CLK);
      checkVal("rstBusy", {31'd0, BUSY}, 0);
      checkVal("rstRspValid", {30'd0, RSP_VALID}, 0);
      checkVal("rstFout", RSP_FOUT, 0);
      checkVal("rstFlags", RSP_FLAGS, 0);
      checkVal("rstOpCount", OP_COUNT, 0);
      checkVal("rstAluA", ALU_A, 0);
      tick;
      RESET_N = 1'b1;

      // Single request: READY same cycle, response two cycles later
      RSP_READY = 2'b11;
      setReq(0, 16'h0001, 16'h0002, 4'd0, 1'b0);
      @(negedge CLK);
      checkVal("t1Ready", {30'd0, REQ_READY}, 2'b01);
      tick;
      REQ_VALID = 2'b00;
      @(negedge CLK);
      checkVal("t1ExecRspValid", {30'd0, RSP_VALID}, 0);
      checkVal("t1ExecBusy", {31'd0, BUSY}, 1);
      checkVal("t1ExecAluA", ALU_A, 16'h0001);
      checkVal("t1ExecReady", {30'd0, REQ_READY}, 0);
      tick;
      @(negedge CLK);
      checkVal("t1RspValid", {30'd0, RSP_VALID}, 2'b01);
      checkVal("t1Fout", RSP_FOUT, 16'h0003);
      checkVal("t1Flags", RSP_FLAGS, 4'b0000);
      tick;
      @(negedge CLK);
      checkVal("t1IdleBusy", {31'd0, BUSY}, 0);
      checkVal("t1OpCount", OP_COUNT, 1);
      checkVal("t1AluHold", ALU_A, 16'h0001);
      tick;

      // Contention from reset: req0 first, then req1
      doReset;
      setReq(0, 16'h0010, 16'h0020, 4'd0, 1'b0);
      setReq(1, 16'h0100, 16'h0005, 4'd0, 1'b1);
      waitGrant("t2Grant0", 2'b01, 1'b1);
      waitDone("t2Done0", fo, fl);
      checkVal("t2Prio", {31'd0, dut.prio}, 1);
      waitGrant("t2Grant1", 2'b10, 1'b1);
      waitDone("t2Done1", fo, fl);
      checkVal("t2Fout1", fo, 16'h0106);
      @(negedge CLK);
      checkVal("t2OpCount", OP_COUNT, 2);
      tick;

      // Overflow / carry / zero flags, plus a subtract
      setReq(0, 16'h7FFF, 16'h0001, 4'd0, 1'b0);
      waitGrant("t3GrantA", 2'b01, 1'b1);
      waitDone("t3DoneA", fo, fl);
      checkVal("t3FoutA", fo, 16'h8000);
      checkVal("t3FlagsA", fl, 4'b0011);
      setReq(0, 16'hFFFF, 16'h0001, 4'd0, 1'b0);
      waitGrant("t3GrantB", 2'b01, 1'b1);
      waitDone("t3DoneB", fo, fl);
      checkVal("t3FoutB", fo, 16'h0000);
      checkVal("t3FlagsB", fl, 4'b1100);
      setReq(1, 16'h0005, 16'h0007, 4'd1, 1'b1);
      waitGrant("t3GrantSub", 2'b10, 1'b1);
      waitDone("t3DoneSub", fo, fl);
      checkVal("t3FoutSub", fo, 16'hFFFE);

      // Backpressure: response held, pending req1 waits past the handshake
      RSP_READY = 2'b00;
      setReq(0, 16'h1234, 16'h1111, 4'd0, 1'b0);
      waitGrant("t4Grant0", 2'b01, 1'b1);
      setReq(1, 16'h0AAA, 16'h0555, 4'd2, 1'b0);
      @(negedge CLK);
      checkVal("t4ExecReady", {30'd0, REQ_READY}, 0);
      tick;
      @(negedge CLK);
      checkVal("t4RspValid", {30'd0, RSP_VALID}, 2'b01);
      checkVal("t4Fout", RSP_FOUT, 16'h2345);
      for (int i = 0; i < 5; i++) begin
         tick;
         if (i == 2) RSP_READY = 2'b10;
         @(negedge CLK);
         checkVal("t4HoldValid", {30'd0, RSP_VALID}, 2'b01);
         checkVal("t4HoldFout", RSP_FOUT, 16'h2345);
         checkVal("t4HoldReady", {30'd0, REQ_READY}, 0);
      end
      tick;
      RSP_READY = 2'b01;
      @(negedge CLK);
      checkVal("t4HsReady", {30'd0, REQ_READY}, 0);
      tick;
      @(negedge CLK);
      checkVal("t4NextReady", {30'd0, REQ_READY}, 2'b10);
      tick;
      REQ_VALID = 2'b00;
      RSP_READY = 2'b11;
      waitDone("t4Done1", fo, fl);
      checkVal("t4Fout1", fo, 16'h0000);

      // Reset during EXEC drops the operation
      setReq(0, 16'h0040, 16'h0002, 4'd0, 1'b0);
      waitGrant("t5Grant", 2'b01, 1'b1);
      RESET_N = 1'b0;
      tick;
      RESET_N = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         checkVal("t5NoRsp", {30'd0, RSP_VALID}, 0);
         tick;
      end
      @(negedge CLK);
      checkVal("t5OpCount", OP_COUNT, 0);
      checkVal("t5Busy", {31'd0, BUSY}, 0);
      checkVal("t5AluA", ALU_A, 0);
      tick;

      // Operation counter wraps
      force dut.opCount = 16'hFFFF;
      tick;
      release dut.opCount;
      @(negedge CLK);
      checkVal("t6Preload", OP_COUNT, 16'hFFFF);
      tick;
      setReq(0, 16'h0001, 16'h0001, 4'd0, 1'b0);
      waitGrant("t6Grant", 2'b01, 1'b1);
      waitDone("t6Done", fo, fl);
      @(negedge CLK);
      checkVal("t6Wrap", OP_COUNT, 16'h0000);
      tick;

`ifdef ALU_ARB_LOCK_EN
      // Lock: req0 granted twice before req1
      doReset;
      REQ_LOCK = 2'b01;
      setReq(0, 16'h0011, 16'h0001, 4'd0, 1'b0);
      setReq(1, 16'h0022, 16'h0002, 4'd0, 1'b0);
      waitGrant("t7Lock0a", 2'b01, 1'b0);
      REQ_LOCK = 2'b00;
      waitDone("t7Done0a", fo, fl);
      checkVal("t7PrioHeld", {31'd0, dut.prio}, 0);
      waitGrant("t7Lock0b", 2'b01, 1'b1);
      waitDone("t7Done0b", fo, fl);
      waitGrant("t7Lock1", 2'b10, 1'b1);
      waitDone("t7Done1", fo, fl);
`else
      // Strict alternation with both requesters continuously valid
      doReset;
      setReq(0, 16'h0011, 16'h0001, 4'd0, 1'b0);
      setReq(1, 16'h0022, 16'h0002, 4'd0, 1'b0);
      waitGrant("t7Rr0", 2'b01, 1'b0);
      waitDone("t7Done0", fo, fl);
      waitGrant("t7Rr1", 2'b10, 1'b0);
      waitDone("t7Done1", fo, fl);
      waitGrant("t7Rr2", 2'b01, 1'b1);
      waitDone("t7Done2", fo, fl);
      waitGrant("t7Rr3", 2'b10, 1'b1);
      waitDone("t7Done3", fo, fl);
`endif

      tick; tick;
      checkVal("sbEmpty", sbQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: RESET_N  in  1  synchronous active-low reset.
REQ-003 SHALL have ports: REQ_VALID  in  2  request valid, bit n = requester n.
REQ-004 SHALL have ports: REQ_READY  out  2  request accepted when VALID&READY.
REQ-005 SHALL have ports: REQ_A  in  32  operand A, requester n at [16n+15:16n].
REQ-006 SHALL have ports: REQ_B  in  32  operand B, same packing.
REQ-007 SHALL have ports: REQ_FSEL  in  8  function select, requester n at [4n+3:4n].
REQ-008 SHALL have ports: REQ_CIN  in  2  carry-in per requester.
REQ-009 SHALL have ports: RSP_VALID  out  2  result valid to requester n.
REQ-010 SHALL have ports: RSP_READY  in  2  requester n takes result.
REQ-011 SHALL have ports: RSP_FOUT  out  16  result, shared by both requesters.
REQ-012 SHALL have ports: RSP_FLAGS  out  4  {C,Z,S,V} of result.
REQ-013 SHALL have ports: ALU_A, ALU_B  out  16 each, ALU_FSEL  out  4, ALU_CIN  out  1  drive the shared combinational ALU.
REQ-014 SHALL have ports: ALU_FOUT  in  16, ALU_C, ALU_Z, ALU_S, ALU_V  in  1 each  ALU outputs.
REQ-015 SHALL have ports: BUSY  out  1  high in any state other than IDLE; OP_COUNT  out  16  completed-operation count.

Function
REQ-016 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE, one transition per cycle except the RESP hold.
REQ-017 In IDLE, SHALL assert REQ_READY[g] combinationally for exactly one winner g with REQ_VALID[g]=1; REQ_READY SHALL be 0 in EXEC and RESP.
REQ-018 Arbitration: a single valid requester wins; when both are valid, the requester indicated by priority pointer PRIO wins.
REQ-019 On acceptance, SHALL register A, B, FSEL, CIN and grant index g, and go to EXEC.
REQ-020 In EXEC, ALU_* outputs SHALL equal the registered operands; ALU_FOUT and the flags SHALL be captured into result registers at the end of EXEC; then go to RESP.
REQ-021 Outside EXEC, ALU_* outputs SHALL keep their last registered values (no glitching to zero).
REQ-022 In RESP, RSP_VALID[g]=1 and RSP_VALID[~g]=0; RSP_FOUT and RSP_FLAGS SHALL stay stable until RSP_READY[g]=1.
REQ-023 On the RSP_VALID[g]&RSP_READY[g] cycle: go to IDLE, set PRIO=~g, increment OP_COUNT (wraps 0xFFFF->0x0000).
REQ-024 Latency: acceptance at cycle T gives RSP_VALID at T+2; minimum spacing between acceptances is 3 cycles.
REQ-025 RSP_READY[~g] and REQ_VALID changes during EXEC/RESP SHALL be ignored; a request still pending is arbitrated at the next IDLE.

Reset
REQ-026 When RESET_N=0 at a clock edge: state=IDLE, PRIO=0, OP_COUNT=0, RSP_VALID=0, RSP_FOUT=0, RSP_FLAGS=0, ALU_* outputs=0, BUSY=0.
REQ-027 A reset during EXEC or RESP SHALL discard the in-flight operation; no response is issued afterwards.

Configuration
REQ-028 Macro ALU_ARB_LOCK_EN defined: adds input REQ_LOCK [1:0]; an accepted request with LOCK=1 makes the next IDLE grant only that requester, ignoring the other, until that requester's next accepted request has LOCK=0; PRIO is not updated while locked.
REQ-029 Macro undefined: REQ_LOCK port absent; strict round-robin per REQ-018/023.

Structure
REQ-030 Package alu_arb_pkg SHALL hold the FSM state encoding, the data width (16), the requester count (2) and the RSP_FLAGS bit positions (C=3, Z=2, S=1, V=0).
REQ-031 Grant selection SHALL be a sub-module rr_arb2 (inputs: valid[1:0], prio, optional lock mask; outputs: grant index and grant-valid).

Verification
(Bench ALU model: FSEL 0000 = A+B+CIN.)
REQ-032 Single request: req0 A=0x0001, B=0x0002, FSEL=0000, CIN=0 -> READY[0] in the same cycle, RSP_VALID[0] 2 cycles later, FOUT=0x0003, FLAGS=0000.
REQ-033 Contention: both valid from reset -> req0 served first, then req1; PRIO=1 after the first response; OP_COUNT=2.
REQ-034 Overflow flags: A=0x7FFF, B=0x0001 -> FOUT=0x8000, S=1, V=1, C=0, Z=0; A=0xFFFF, B=0x0001 -> FOUT=0x0000, C=1, Z=1.
REQ-035 Backpressure: hold RSP_READY[0]=0 for 5 cycles -> RSP_VALID and FOUT stable; a pending req1 is not accepted until one cycle after the handshake.
REQ-036 Reset mid-EXEC -> no RSP_VALID, OP_COUNT=0; OP_COUNT wrap: preload 0xFFFF, complete one op -> 0x0000.
REQ-037 With ALU_ARB_LOCK_EN: req0 with LOCK=1 and both valid -> req0 granted twice in a row before req1.
